// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned NUM_SLOTS     = 4;
  localparam int unsigned SLOT_BITS     = 2;
  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned bit_cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position counters for the TDM demux; indices name the next bit to be sampled.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned BIT_W = bit_cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  input  logic                 restart,
  input  logic                 clear,
  output logic [BIT_W-1:0]     bit_idx,
  output logic [SLOT_BITS-1:0] slot_idx,
  output logic                 bit_wrap,
  output logic                 frame_wrap
);

  always_comb begin
    bit_wrap   = (bit_idx == BIT_W'(WIDTH - 1));
    frame_wrap = bit_wrap && (slot_idx == SLOT_BITS'(NUM_SLOTS - 1));
  end

  // restart means the current sample was slot 0 bit 0, so the next bit is bit 1
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_idx  <= '0;
      slot_idx <= '0;
    end else if (restart) begin
      bit_idx  <= BIT_W'(1);
      slot_idx <= '0;
    end else if (advance) begin
      if (bit_wrap) begin
        bit_idx  <= '0;
        slot_idx <= frame_wrap ? '0 : slot_idx + 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Serial 4-slot TDM demultiplexer with frame-sync hunting and lock supervision.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic             sel1,
  output logic             sel0,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam int unsigned BIT_W = bit_cnt_width(WIDTH);

  state_t                 state;
  logic [WIDTH-1:0]       shift_reg;
  logic [WIDTH-1:0]       staging [NUM_SLOTS];
  logic                   load_pending;

  logic [BIT_W-1:0]       bit_idx;
  logic [SLOT_BITS-1:0]   slot_idx;
  logic                   bit_wrap;
  logic                   frame_wrap;

  logic                   locked;
  logic                   at_start;
  logic                   missed_sync;
  logic                   early_sync;
  logic                   restart;
  logic                   take_bit;
  logic [WIDTH-1:0]       next_word;

  always_comb begin
    locked      = (state == LOCKED);
    at_start    = (bit_idx == '0) && (slot_idx == '0);
    missed_sync = enable && locked && at_start && !frame_sync;
    early_sync  = enable && locked && !at_start && frame_sync;
    // covers both the initial lock from HUNT and a resync on an unexpected sync
    restart     = enable && frame_sync && (!locked || !at_start);
    take_bit    = enable && locked && !missed_sync && !early_sync;
    next_word   = {shift_reg[WIDTH-2:0], din};
  end

  tdm_slot_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .advance   (take_bit),
    .restart   (restart),
    .clear     (missed_sync),
    .bit_idx   (bit_idx),
    .slot_idx  (slot_idx),
    .bit_wrap  (bit_wrap),
    .frame_wrap(frame_wrap)
  );

  assign sel1 = slot_idx[1];
  assign sel0 = slot_idx[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      shift_reg    <= '0;
      load_pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        staging[i] <= '0;
      end
      data0        <= '0;
      data1        <= '0;
      data2        <= '0;
      data3        <= '0;
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      // Outputs load one edge after the closing bit, independent of enable, so a
      // violation on that edge cannot suppress the completed frame.
      frame_valid  <= load_pending;
      load_pending <= 1'b0;
      if (load_pending) begin
        data0 <= staging[0];
        data1 <= staging[1];
        data2 <= staging[2];
        data3 <= staging[3];
      end

      // A stuck-high sync would otherwise raise sync_err on consecutive samples.
      sync_err <= (missed_sync || early_sync) && !sync_err;

      if (restart) begin
        state     <= LOCKED;
        shift_reg <= {{(WIDTH-1){1'b0}}, din};
      end else if (missed_sync) begin
        state     <= HUNT;
        shift_reg <= '0;
      end else if (take_bit) begin
        shift_reg <= next_word;
        if (bit_wrap) begin
          staging[slot_idx] <= next_word;
        end
        if (frame_wrap) begin
          load_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 at WIDTH=8.
module tb_tdm_demux4;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         din = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] data0, data1, data2, data3;
  logic         sel1, sel0, frame_valid, sync_err;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   fv_count = 0;
  int   se_count = 0;
  logic prev_fv = 1'b0;
  logic prev_se = 1'b0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .din        (din),
    .frame_sync (frame_sync),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .sel1       (sel1),
    .sel0       (sel0),
    .frame_valid(frame_valid),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every frame_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (frame_valid && prev_fv) begin
        errors++;
        $display("FAIL fv_one_cycle: frame_valid high two cycles at cyc %0d", cyc);
      end
      checks++;
      if (sync_err && prev_se) begin
        errors++;
        $display("FAIL se_one_cycle: sync_err high two cycles at cyc %0d", cyc);
      end
      if (sync_err) se_count++;
      if (frame_valid) begin
        fv_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_fv: frame_valid at cyc %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({data0, data1, data2, data3} !== e.data) begin
            errors++;
            $display("FAIL frame_data: got %h required %h", {data0, data1, data2, data3}, e.data);
          end
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL fv_latency: frame_valid at cyc %0d required cyc %0d", cyc, e.due);
          end
        end
      end
    end
    prev_fv = frame_valid;
    prev_se = sync_err;
  end

  task automatic drive(input logic en, input logic b, input logic fs);
    enable     = en;
    din        = b;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Sends one synced frame with ngaps enable-low cycles at random inner positions.
  task automatic send_frame(input logic [31:0] frame, input int ngaps);
    logic [31:0] gmask;
    int          placed;
    int          start;
    int unsigned p;
    logic [1:0]  exp_sel;
    gmask  = '0;
    placed = 0;
    while (placed < ngaps) begin
      p = $urandom_range(1, 31);
      if (!gmask[p]) begin
        gmask[p] = 1'b1;
        placed++;
      end
    end
    start = cyc;
    for (int i = 0; i < 32; i++) begin
      if (gmask[i]) drive(1'b0, 1'($urandom), 1'($urandom));
      drive(1'b1, frame[31-i], i == 0);
      exp_sel = 2'(((i + 1) / W) % 4);
      checks++;
      if ({sel1, sel0} !== exp_sel) begin
        errors++;
        $display("FAIL sel_track: bit %0d sel %0d required %0d", i, {sel1, sel0}, exp_sel);
      end
    end
    sb.push_back('{data: frame, due: start + 32 + ngaps + 1});
  endtask

  task automatic drain();
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_fv: %0d frames outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data0, data1, data2, data3, sel1, sel0, frame_valid, sync_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0",
               {data0, data1, data2, data3, sel1, sel0, frame_valid, sync_err});
    end
  endtask

  task automatic test_back_to_back();
    int fv0, se0;
    do_reset();
    fv0 = fv_count;
    se0 = se_count;
    repeat (4) send_frame(32'hA53CFF01, 0);
    drain();
    checks++;
    if (fv_count - fv0 !== 4) begin
      errors++;
      $display("FAIL b2b_fv_count: got %0d required 4", fv_count - fv0);
    end
    checks++;
    if (se_count - se0 !== 0) begin
      errors++;
      $display("FAIL b2b_sync_err: got %0d required 0", se_count - se0);
    end
  endtask

  task automatic test_enable_gaps();
    int se0;
    do_reset();
    se0 = se_count;
    send_frame(32'hA53CFF01, 3);
    send_frame(32'hA53CFF01, 3);
    drain();
    checks++;
    if (se_count - se0 !== 0) begin
      errors++;
      $display("FAIL gap_sync_err: got %0d required 0", se_count - se0);
    end
  endtask

  task automatic test_early_sync();
    logic [31:0] part;
    int          se0;
    part = 32'h6699C33C;
    do_reset();
    send_frame(32'h0F1E2D3C, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, part[31-i], i == 0);
    se0 = se_count;
    send_frame(32'h5AC3817E, 0);
    drain();
    checks++;
    if (se_count - se0 !== 1) begin
      errors++;
      $display("FAIL early_sync_err: got %0d pulses required 1", se_count - se0);
    end
  endtask

  task automatic test_missed_sync();
    int se0;
    do_reset();
    send_frame(32'h11223344, 0);
    se0 = se_count;
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL missed_sync_err: got %b required 1", sync_err);
    end
    checks++;
    if ({sel1, sel0} !== 2'd0) begin
      errors++;
      $display("FAIL missed_sel: got %0d required 0", {sel1, sel0});
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom), 1'b0);
      checks++;
      if ({sel1, sel0} !== 2'd0) begin
        errors++;
        $display("FAIL hunt_sel: step %0d got %0d required 0", i, {sel1, sel0});
      end
    end
    checks++;
    if (se_count - se0 !== 1) begin
      errors++;
      $display("FAIL missed_err_count: got %0d required 1", se_count - se0);
    end
    send_frame(32'hDEADBEEF, 0);
    drain();
  endtask

  task automatic test_mid_reset();
    logic [31:0] nxt;
    nxt = 32'hC0FFEE42;
    do_reset();
    send_frame(32'hA53CFF01, 0);
    for (int i = 0; i < 21; i++) drive(1'b1, nxt[31-i], i == 0);
    checks++;
    if (data0 !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset_data: got %h required a5", data0);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if ({data0, data1, data2, data3, sel1, sel0, frame_valid, sync_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h required 0",
               {data0, data1, data2, data3, sel1, sel0, frame_valid, sync_err});
    end
    rst = 1'b0;
    send_frame(32'h7E81A55A, 0);
    drain();
  endtask

  task automatic test_sync_while_disabled();
    do_reset();
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    checks++;
    if ({sel1, sel0} !== 2'd0) begin
      errors++;
      $display("FAIL disabled_sel: got %0d required 0", {sel1, sel0});
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'($urandom), 1'b0);
      checks++;
      if ({sel1, sel0, sync_err} !== 3'd0) begin
        errors++;
        $display("FAIL disabled_lock: step %0d sel/err %b required 000", i, {sel1, sel0, sync_err});
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_enable_gaps();
    test_early_sync();
    test_missed_sync();
    test_mid_reset();
    test_sync_while_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, 8, bits per slot; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  when high, din and frame_sync are sampled this cycle.
REQ-005 Port: din  input  1  serial TDM stream; 4 slots per frame, WIDTH bits each, MSB first.
REQ-006 Port: frame_sync  input  1  high with the first bit (MSB) of slot 0.
REQ-007 Port: data0..data3  output  WIDTH each  last complete word of slots 0..3.
REQ-008 Port: sel1, sel0  output  1 each  slot index of the next bit to be sampled; sel1 is the MSB.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when data0..data3 update.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-011 The FSM SHALL have two states: HUNT and LOCKED.
REQ-012 A sample SHALL occur only on cycles with enable=1; with enable=0, counters, shift register and state SHALL hold, and frame_sync SHALL be ignored.
REQ-013 In HUNT, a sample with frame_sync=0 SHALL be discarded.
REQ-014 In HUNT, a sample with frame_sync=1 SHALL be taken as bit 0 of slot 0, and the FSM SHALL enter LOCKED.
REQ-015 Bit counter 0..WIDTH-1 and slot counter 0..3 SHALL advance once per sample.
  - The slot counter SHALL advance when the bit counter wraps.
  - The slot counter SHALL wrap 3->0 after the last bit of slot 3.
REQ-016 Each slot's bits SHALL shift into a working register MSB first; at slot end, the word SHALL be stored to staging entry [slot].
REQ-017 When the last bit of slot 3 is sampled in cycle N, all four of data0..data3 SHALL load together from staging, and frame_valid SHALL pulse, at edge N+1 (one-cycle latency).
  - Between updates, data0..data3 SHALL hold; a partial frame SHALL never be visible.
REQ-018 In LOCKED, frame_sync=1 on the expected bit (slot 0, bit 0) SHALL be accepted silently.
REQ-019 In LOCKED, frame_sync=0 on the expected bit SHALL:
  - pulse sync_err;
  - discard the sample;
  - return the FSM to HUNT.
REQ-020 In LOCKED, frame_sync=1 on any other bit SHALL:
  - pulse sync_err;
  - discard the partial frame (no frame_valid);
  - restart as slot 0 bit 0 with this sample; the FSM SHALL stay LOCKED.
REQ-021 If frame_valid and a violation fall on the same edge, frame_valid SHALL still fire for the completed frame.
REQ-022 sel1/sel0 SHALL show the slot counter, and SHALL read 0 in HUNT.
REQ-023 frame_valid and sync_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-024 Reset SHALL be synchronous: when rst=1 at an edge, the FSM SHALL go to HUNT; counters, working register, staging, data0..data3, sel1/sel0, frame_valid and sync_err SHALL go to 0.
REQ-025 rst SHALL take priority over enable and frame_sync.
REQ-026 Reset mid-frame SHALL discard the partial frame without pulsing frame_valid or sync_err.

Structure
REQ-027 Package tdm_pkg SHALL hold:
  - the state enum (HUNT, LOCKED);
  - NUM_SLOTS=4;
  - DEFAULT_WIDTH=8.
REQ-028 One sub-module, tdm_slot_counter, SHALL implement the bit/slot counters with enable, restart and wrap outputs; all else stays in tdm_demux4.
REQ-029 All outputs SHALL be registered.

Verification (WIDTH=8)
REQ-030 Four frames are sent back-to-back with correct sync, slots A5,3C,FF,01:
  - data0..3=A5,3C,FF,01 one cycle after the 32nd bit;
  - frame_valid pulses once per frame;
  - sync_err stays 0.
REQ-031 The same frame is sent with enable low for 3 cycles at random points:
  - identical data;
  - frame_valid is delayed by exactly the gap cycles.
REQ-032 frame_sync is raised at slot 1 bit 2 while LOCKED:
  - sync_err pulses;
  - no frame_valid for the partial frame;
  - the next full frame from that point decodes correctly.
REQ-033 frame_sync is omitted at the expected slot 0 bit 0:
  - sync_err pulses, FSM is in HUNT, and sel reads 0;
  - no frame_valid until a new sync arrives and a full frame is received.
REQ-034 rst is asserted at slot 2 bit 5:
  - all outputs are 0 on the next edge;
  - a previously valid data0..3 is cleared;
  - a fresh synced frame decodes correctly.
REQ-035 frame_sync=1 is applied with enable=0 in HUNT: no lock, and sel stays 0.
